// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch / data) in front of a single shared memory port.
// Latency: a request sampled at edge N drives mem_req from cycle N+1; the ack is
// combinational with mem_ack. Requesters hold until ack; one IDLE cycle between grants.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: round-robin on collisions, else data wins.
module mem_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_D  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   any_req;
    logic   grant;
    logic   pick_d;

    assign any_req = if_req | d_req;
    assign grant   = (state == IDLE) && any_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // last_d = 1 means the data side won the previous arbitration
    logic last_d;

    always_comb begin
        pick_d = d_req && (!if_req || !last_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_d <= 1'b1;
        end else if (grant) begin
            last_d <= pick_d;
        end
    end
`else
    always_comb begin
        pick_d = d_req;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if_ack    = 1'b0;
        d_ack     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = pick_d ? GNT_D : GNT_IF;
                end
            end
            GNT_IF: begin
                if (mem_ack) begin
                    if_ack    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            GNT_D: begin
                if (mem_ack) begin
                    d_ack     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command is captured once at grant and held for the whole transaction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant) begin
            mem_we    <= pick_d ? d_we : 1'b0;
            mem_addr  <= pick_d ? d_addr : if_addr;
            mem_wdata <= pick_d ? d_wdata : '0;
        end
    end

    assign mem_req  = (state != IDLE);
    assign busy     = (state != IDLE);
    assign if_rdata = if_ack ? mem_rdata : '0;
    assign d_rdata  = d_ack ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model plus per-cycle compare,
// with literal expectations pinning the key scenarios.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_ack;
    logic [63:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [63:0] d_addr = '0;
    logic [63:0] d_wdata = '0;
    logic        d_ack;
    logic [63:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the memory port (0 none, 1 fetch, 2 data) and the command it issued
    int          owner = 0;
    bit          last_was_d = 1'b1;
    logic [63:0] exp_addr = '0;
    logic        exp_we = 1'b0;
    logic [63:0] exp_wdata = '0;
    int          grants[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner      = 0;
            last_was_d = 1'b1;
        end else if (owner != 0) begin
            if (mem_ack) owner = 0;
        end else if (if_req || d_req) begin
            bit data_wins;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            data_wins = d_req && !(if_req && last_was_d);
`else
            data_wins = d_req;
`endif
            last_was_d = data_wins;
            owner      = data_wins ? 2 : 1;
            exp_addr   = data_wins ? d_addr : if_addr;
            exp_we     = data_wins ? d_we : 1'b0;
            exp_wdata  = d_wdata;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("mem_req", 64'(mem_req), 64'(owner != 0));
            chk("busy", 64'(busy), 64'(owner != 0));
            chk("if_ack", 64'(if_ack), 64'(owner == 1 && mem_ack));
            chk("d_ack", 64'(d_ack), 64'(owner == 2 && mem_ack));
            chk("if_rdata", if_rdata, (owner == 1 && mem_ack) ? mem_rdata : 64'h0);
            chk("d_rdata", d_rdata, (owner == 2 && mem_ack) ? mem_rdata : 64'h0);
            if (owner != 0) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_we", 64'(mem_we), 64'(exp_we));
                if (owner == 2) chk("mem_wdata", mem_wdata, exp_wdata);
            end
            if (if_ack) grants.push_back(1);
            if (d_ack) grants.push_back(2);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int exp_g[4];

    initial begin
        #2;
        chk("rst_mem_req", 64'(mem_req), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_mem_addr", mem_addr, 64'h0);
        chk("rst_mem_wdata", mem_wdata, 64'h0);
        chk("rst_mem_we", 64'(mem_we), 64'h0);
        #10 reset = 1'b1;

        // Single fetch, memory answers in the second grant cycle
        step();
        if_req = 1'b1; if_addr = 64'h40;
        step();
        chk("f_mem_req_c1", 64'(mem_req), 64'h1);
        chk("f_mem_addr", mem_addr, 64'h40);
        chk("f_mem_we", 64'(mem_we), 64'h0);
        chk("f_no_ack_c1", 64'(if_ack), 64'h0);
        step();
        chk("f_mem_req_c2", 64'(mem_req), 64'h1);
        mem_ack = 1'b1; mem_rdata = 64'h13;
        #1;
        chk("f_if_ack", 64'(if_ack), 64'h1);
        chk("f_if_rdata", if_rdata, 64'h13);
        step();
        if_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        chk("f_idle_gap", 64'(mem_req), 64'h0);

        // Store
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h100; d_wdata = 64'hDEADBEEF;
        step();
        mem_ack = 1'b1; mem_rdata = 64'h55;
        #1;
        chk("s_mem_we", 64'(mem_we), 64'h1);
        chk("s_mem_wdata", mem_wdata, 64'hDEADBEEF);
        chk("s_d_ack", 64'(d_ack), 64'h1);
        chk("s_no_if_ack", 64'(if_ack), 64'h0);
        step();

        // Both requesters held, memory acks immediately
        grants.delete();
        if_req = 1'b1; if_addr = 64'h80;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h180;
        mem_ack = 1'b1; mem_rdata = 64'hA5;
        repeat (8) step();
        d_req = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_g[0] = 1; exp_g[1] = 2; exp_g[2] = 1; exp_g[3] = 2;
`else
        exp_g[0] = 2; exp_g[1] = 2; exp_g[2] = 2; exp_g[3] = 2;
`endif
        chk("c_grant_count", 64'(grants.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("c_grant%0d", i), 64'(grants.size() > i ? grants[i] : 0), 64'(exp_g[i]));
        end
        step();
        chk("c_if_after_d", 64'(if_ack), 64'h1);
        step();
        if_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0;

        // Async reset in the middle of a data grant, then replay
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h200;
        step();
        chk("r_mem_req_pre", 64'(mem_req), 64'h1);
        #1;
        reset = 1'b0; mem_ack = 1'b1;
        #1;
        chk("r_mem_req_drop", 64'(mem_req), 64'h0);
        chk("r_no_d_ack", 64'(d_ack), 64'h0);
        chk("r_busy", 64'(busy), 64'h0);
        chk("r_mem_addr", mem_addr, 64'h0);
        #5;
        reset = 1'b1; mem_ack = 1'b0;
        step();
        chk("r_replay_req", 64'(mem_req), 64'h1);
        chk("r_replay_addr", mem_addr, 64'h200);
        mem_ack = 1'b1; mem_rdata = 64'h77;
        #1;
        chk("r_replay_ack", 64'(d_ack), 64'h1);
        chk("r_replay_rdata", d_rdata, 64'h77);
        step();
        d_req = 1'b0;

        // Stray mem_ack while idle
        repeat (3) begin
            step();
            chk("i_busy", 64'(busy), 64'h0);
            chk("i_if_ack", 64'(if_ack), 64'h0);
            chk("i_d_ack", 64'(d_ack), 64'h0);
        end
        mem_ack = 1'b0;
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
